edge_stage_sequencer: RTL and testbench

// Frame-level controller for the edge-detection stages (gaussian, sobel, NMS, double threshold, hysteresis).

---
 rtl/edge_stage_sequencer_pkg.sv | 24 ++
 rtl/edge_stage_sequencer_if.sv | 31 +++
 rtl/edge_stage_sequencer_watchdog.sv | 26 ++
 rtl/edge_stage_sequencer.sv | 125 ++++++++++++
 tb/tb_edge_stage_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_stage_sequencer_pkg.sv
// Shared types and constants for the edge-detection stage sequencer.
package edge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT,
        FINISH,
        ERROR
    } seq_state_t;

    // Stage order through the edge-detection pipeline.
    localparam int STAGE_GAUSS   = 0;
    localparam int STAGE_SOBEL   = 1;
    localparam int STAGE_NMS     = 2;
    localparam int STAGE_DTHRESH = 3;
    localparam int STAGE_HYST    = 4;

    localparam int DEF_NUM_STAGES     = 5;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/edge_stage_sequencer_if.sv
// Control/stage bundle between the host register block, the stages and the sequencer.
interface edge_stage_sequencer_if #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    logic                  frame_start;
    logic                  abort;
    logic [NUM_STAGES-1:0] bypass_mask;
    logic [NUM_STAGES-1:0] stage_enable;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  busy;
    logic [IDX_W-1:0]      active_stage;
    logic                  frame_done;
    logic                  error;
    logic [IDX_W-1:0]      err_stage;
    logic [CNT_W-1:0]      frame_count;

    // Host + stage side.
    modport master (
        output frame_start, abort, bypass_mask, stage_done,
        input  stage_enable, busy, active_stage, frame_done, error, err_stage, frame_count
    );

    // Sequencer side.
    modport slave (
        input  frame_start, abort, bypass_mask, stage_done,
        output stage_enable, busy, active_stage, frame_done, error, err_stage, frame_count
    );
endinterface

// File: rtl/edge_stage_sequencer_watchdog.sv
// Per-stage hang detector: counts cycles spent waiting on the active stage.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] count;

    assign expired = (count == TW'(TIMEOUT_CYCLES - 1));

    // Clear on launch, count while waiting, hold once expired so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/edge_stage_sequencer.sv
// Frame sequencer for the edge-detection stages: launches each non-bypassed
// stage in index order and advances only on a rising edge of its done level.
module edge_stage_sequencer
    import edge_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    edge_stage_sequencer_if.slave bus
);
    localparam int               IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [IDX_W-1:0] NONE  = IDX_W'(NUM_STAGES);

    seq_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [NUM_STAGES-1:0] mask;
    logic [NUM_STAGES-1:0] done_q;
    logic [NUM_STAGES-1:0] sel;
    logic                  cur_bypass;
    logic                  cur_edge;
    logic                  wd_expired;

    // One-hot of the selected stage; shifts out to zero once idx == NUM_STAGES.
    assign sel        = NUM_STAGES'(1) << idx;
    assign cur_bypass = |(mask & sel);
    // A level still high from a previous run is not a completion.
    assign cur_edge   = |(bus.stage_done & ~done_q & sel);

    stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == LAUNCH),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );

    // Previous-cycle done levels for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done_q <= '0;
        else
            done_q <= bus.stage_done;
    end

    // Sequencer FSM; busy/active_stage are set alongside each transition so
    // they always describe the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= '0;
            mask             <= '0;
            bus.stage_enable <= '0;
            bus.busy         <= 1'b0;
            bus.active_stage <= NONE;
            bus.frame_done   <= 1'b0;
            bus.error        <= 1'b0;
            bus.err_stage    <= '0;
            bus.frame_count  <= '0;
        end else begin
            bus.stage_enable <= '0;
            bus.frame_done   <= 1'b0;
            if (bus.abort && state != IDLE) begin
                // Abort beats everything, including a same-cycle done edge or timeout.
                state            <= IDLE;
                bus.busy         <= 1'b0;
                bus.active_stage <= NONE;
                bus.error        <= 1'b0;
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        if (bus.frame_start && !bus.abort) begin
                            mask             <= bus.bypass_mask;
                            idx              <= '0;
                            bus.error        <= 1'b0;
                            bus.busy         <= 1'b1;
                            bus.active_stage <= '0;
                            state            <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (idx == NONE) begin
                            state <= FINISH;
                        end else if (cur_bypass) begin
                            idx              <= idx + 1'b1;
                            bus.active_stage <= idx + 1'b1;
                        end else begin
                            state <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        bus.stage_enable <= sel;
                        state            <= WAIT;
                    end
                    WAIT: begin
                        if (cur_edge) begin
                            idx              <= idx + 1'b1;
                            bus.active_stage <= idx + 1'b1;
                            state            <= SELECT;
                        end else if (wd_expired) begin
                            bus.error        <= 1'b1;
                            bus.err_stage    <= idx;
                            bus.busy         <= 1'b0;
                            bus.active_stage <= NONE;
                            state            <= ERROR;
                        end
                    end
                    FINISH: begin
                        bus.frame_done  <= 1'b1;
                        bus.frame_count <= bus.frame_count + CNT_W'(1);
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                    default: begin
                        bus.busy         <= 1'b0;
                        bus.active_stage <= NONE;
                        state            <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Bench for edge_stage_sequencer: stage models answer enables with programmed
// latencies; expected per-cycle outputs come from a frame timeline computed
// from the stage list, bypass mask and latencies.
module tb_edge_stage_sequencer;
    import edge_pkg::*;

    localparam int NS    = 5;
    localparam int TO    = 16;
    localparam int CW    = 16;
    localparam int NEVER = 1000;
    localparam int TL    = 128;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int model_fc = 0;
    bit model_err = 1'b0;

    int r_lat[NS];
    int r_hold[NS];
    int own_k[NS];
    int en_at[NS];
    int e_en[TL];
    int e_act[TL];
    bit e_busy[TL];
    bit e_fd[TL];
    bit e_err[TL];
    int end_k, kind, e_es;

    edge_stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    edge_stage_sequencer #(.NUM_STAGES(NS), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_checks();
        chk("rst_en", 32'(bus.stage_enable), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_act", 32'(bus.active_stage), 32'(NS));
        chk("rst_fdone", 32'(bus.frame_done), 32'(0));
        chk("rst_err", 32'(bus.error), 32'(0));
        chk("rst_errstage", 32'(bus.err_stage), 32'(0));
        chk("rst_fcount", 32'(bus.frame_count), 32'(0));
    endtask

    task automatic idle_checks();
        chk("idle_en", 32'(bus.stage_enable), 32'(0));
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_act", 32'(bus.active_stage), 32'(NS));
        chk("idle_fdone", 32'(bus.frame_done), 32'(0));
        chk("idle_err", 32'(bus.error), 32'(model_err));
        chk("idle_fcount", 32'(bus.frame_count), 32'(model_fc));
    endtask

    // Expected frame: 1 cycle per bypassed stage, 2 + latency per run stage,
    // then 2 cycles to frame_done; a latency beyond TO errors TO cycles after enable.
    task automatic build(input logic [NS-1:0] m);
        int pos;
        pos  = 0;
        kind = 0;
        for (int k = 0; k < TL; k++) begin
            e_en[k] = 0; e_act[k] = NS; e_busy[k] = 1'b1; e_fd[k] = 1'b0; e_err[k] = 1'b0;
        end
        for (int i = 0; i < NS; i++) en_at[i] = -1;
        for (int i = 0; i < NS && kind == 0; i++) begin
            e_act[pos] = i;
            if (m[i]) begin
                pos++;
            end else begin
                e_act[pos+1] = i;
                pos += 2;
                en_at[i] = pos;
                e_en[pos] = 1 << i;
                if (r_lat[i] > TO) begin
                    for (int k = pos; k < pos + TO; k++) e_act[k] = i;
                    pos += TO;
                    kind = 1;
                    e_es = i;
                end else begin
                    for (int k = pos; k < pos + r_lat[i]; k++) e_act[k] = i;
                    pos += r_lat[i];
                end
            end
        end
        if (kind == 0) begin
            pos += 2;
            e_fd[pos] = 1'b1;
        end else begin
            e_err[pos] = 1'b1;
        end
        end_k = pos;
        e_busy[pos] = 1'b0;
        e_act[pos] = NS;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_fc  = 0;
        model_err = 1'b0;
        rst_checks();
        bus.frame_start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ab: 0 none, >0 abort sampled at that frame cycle, -1 random.
    // rs: stage index to assert reset in while waiting on it, -1 none.
    task automatic run(input logic [NS-1:0] m, input int ab, input int rs);
        int rk, rel;
        build(m);
        if (ab < 0) ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, end_k)) : 0;
        if (ab > 0 && ab <= end_k) begin
            end_k = ab; kind = 2;
            e_en[ab] = 0; e_busy[ab] = 1'b0; e_act[ab] = NS; e_fd[ab] = 1'b0; e_err[ab] = 1'b0;
        end
        rk = (rs >= 0 && en_at[rs] >= 0) ? en_at[rs] + 3 : -1;
        for (int i = 0; i < NS; i++) own_k[i] = -1;
        bus.bypass_mask = m;
        bus.frame_start = 1'b1;
        bus.abort = 1'b0;
        for (int k = 0; k <= end_k; k++) begin
            tick();
            if (k == end_k) begin
                if (kind == 0) model_fc++;
                model_err = (kind == 1);
            end
            chk("enable", 32'(bus.stage_enable), 32'(e_en[k]));
            chk("busy", 32'(bus.busy), 32'(e_busy[k]));
            chk("active", 32'(bus.active_stage), 32'(e_act[k]));
            chk("fdone", 32'(bus.frame_done), 32'(e_fd[k]));
            chk("error", 32'(bus.error), 32'(e_err[k]));
            if (e_err[k]) chk("err_stage", 32'(bus.err_stage), 32'(e_es));
            chk("fcount", 32'(bus.frame_count), 32'(model_fc));
            if (k == rk) begin
                do_reset();
                return;
            end
            for (int i = 0; i < NS; i++)
                if (bus.stage_enable[i]) own_k[i] = k;
            if (k < end_k) begin
                for (int i = 0; i < NS; i++) begin
                    if (own_k[i] >= 0) begin
                        rel = k + 1 - own_k[i];
                        if (rel > r_hold[i]) bus.stage_done[i] = (rel >= r_lat[i]);
                    end else if ($urandom_range(0, 7) == 0) begin
                        bus.stage_done[i] = ~bus.stage_done[i];
                    end
                end
                bus.abort = (k + 1 == ab);
                bus.frame_start = ($urandom_range(0, 3) == 0);
                bus.bypass_mask = NS'($urandom);
            end
        end
        bus.frame_start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic gap(input int n, input bit ab);
        for (int g = 0; g < n; g++) begin
            bus.abort = ab && (g == 0);
            tick();
            if (ab && g == 0) model_err = 1'b0;
            bus.abort = 1'b0;
            idle_checks();
        end
    endtask

    task automatic nominal_lat();
        for (int i = 0; i < NS; i++) begin
            r_lat[i] = 10;
            r_hold[i] = 0;
        end
    endtask

    initial begin
        logic [NS-1:0] m;
        bus.frame_start = 1'b0;
        bus.abort = 1'b0;
        bus.bypass_mask = '0;
        bus.stage_done = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_checks();
        @(negedge clk);
        reset_n = 1'b1;

        // Nominal and bypass frames.
        nominal_lat();
        run('0, 0, -1);
        gap(2, 1'b0);
        run(5'b01010, 0, -1);
        run(5'b11111, 0, -1);

        // Stage 3 done still high from last frame; drops, then re-rises 12 cycles after enable.
        r_hold[STAGE_DTHRESH] = 5;
        r_lat[STAGE_DTHRESH]  = 12;
        run('0, 0, -1);
        nominal_lat();

        // Stage 2 hangs; error holds, then a new frame clears it.
        r_lat[STAGE_NMS] = NEVER;
        run('0, 0, -1);
        gap(3, 1'b0);
        nominal_lat();
        run('0, 0, -1);

        // Abort while waiting on stage 1, then abort on the cycle of its done edge.
        run('0, 18, -1);
        gap(1, 1'b0);
        run('0, 12 * STAGE_SOBEL + 12, -1);
        gap(1, 1'b0);

        // Asynchronous reset while waiting on stage 3, then a clean frame.
        run('0, 0, STAGE_DTHRESH);
        run('0, 0, -1);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            m = NS'($urandom);
            for (int i = 0; i < NS; i++) begin
                r_hold[i] = $urandom_range(0, 2);
                r_lat[i]  = ($urandom_range(0, 15) == 0) ? NEVER
                          : r_hold[i] + 2 + int'($urandom_range(0, 14 - r_hold[i]));
            end
            run(m, -1, -1);
            gap($urandom_range(0, 3), model_err && ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
